// File: rtl/datamemory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
// The pipeline side is the master; the controller is the slave.
interface datamemory_ctrl_if #(
    parameter int DM_ADDRESS = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [31:0]           wd;
    logic [2:0]            Funct3;
    logic                  rsp_valid;
    logic [31:0]           rd;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid, MemRead, MemWrite, a, wd, Funct3,
        input  req_ready, rsp_valid, rd, err, busy
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, a, wd, Funct3,
        output req_ready, rsp_valid, rd, err, busy
    );
endinterface

// File: rtl/datamemory_ctrl.sv
// Multi-cycle RV32 data memory controller: byte/half/word loads and stores,
// configurable wait states, and error reporting for misaligned or illegal
// accesses. The bus interface must be instantiated with the same DM_ADDRESS.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down wait states
// RESP  | one-cycle response strobe
module datamemory_ctrl #(
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 32
) (
    input logic              clk,
    input logic              rst_n,
    datamemory_ctrl_if.slave bus
);
    localparam int IDX_W = DM_ADDRESS - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("datamemory_ctrl: DATA_W must be 32");
    end
    if (DM_ADDRESS < 3 || DM_ADDRESS > 20) begin : g_bad_addr_w
        $error("datamemory_ctrl: DM_ADDRESS must be in 3..20");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("datamemory_ctrl: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DM_ADDRESS-1:0] a_q;
    logic [31:0]           wd_q;
    logic [2:0]            f3_q;
    logic                  load_q;
    logic                  store_q;
    logic                  err_q;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  live_err;
    logic                  enter_resp;
    logic                  do_write;
    logic [DM_ADDRESS-1:0] s_a;
    logic [31:0]           s_wd;
    logic [2:0]            s_f3;
    logic                  s_load;
    logic                  s_store;
    logic                  s_err;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            lane_en;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic [31:0]           shifted;
    logic [31:0]           load_val;

    // Both ops at once, bad funct3 for the op, or a half/word off its natural boundary.
    function automatic logic access_err(logic r, logic w, logic [2:0] f, logic [1:0] lo);
        logic e;
        e = 1'b0;
        if (r && w) begin
            e = 1'b1;
        end else if (r) begin
            if (f == 3'b011 || f == 3'b110 || f == 3'b111) e = 1'b1;
        end else if (w) begin
            if (f[2] || f[1:0] == 2'b11) e = 1'b1;
        end
        if (f[1:0] == 2'b01 && lo[0]) e = 1'b1;
        if (f[1:0] == 2'b10 && lo != 2'b00) e = 1'b1;
        return e;
    endfunction

    assign accept   = bus.req_valid && bus.req_ready && (bus.MemRead || bus.MemWrite);
    assign live_err = access_err(bus.MemRead, bus.MemWrite, bus.Funct3, bus.a[1:0]);

    // With no wait states the RESP-entry edge is the acceptance edge, so the
    // live request drives the datapath in IDLE and the latched copy otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            s_a     = bus.a;
            s_wd    = bus.wd;
            s_f3    = bus.Funct3;
            s_load  = bus.MemRead & ~bus.MemWrite;
            s_store = bus.MemWrite & ~bus.MemRead;
            s_err   = live_err;
        end else begin
            s_a     = a_q;
            s_wd    = wd_q;
            s_f3    = f3_q;
            s_load  = load_q;
            s_store = store_q;
            s_err   = err_q;
        end
    end

    assign enter_resp = (state == ST_WAIT && cnt == 4'd0) ||
                        (state == ST_IDLE && accept && NO_WAIT);
    assign do_write   = enter_resp && s_store && !s_err;
    assign idx        = s_a[DM_ADDRESS-1:2];
    assign rd_word    = mem[idx];
    assign shifted    = rd_word >> {s_a[1:0], 3'b000};

    // Byte-lane enables and replicated store data for the access width.
    always_comb begin
        lane_en = 4'b1111;
        wr_data = s_wd;
        case (s_f3[1:0])
            2'b00: begin
                lane_en = 4'b0001 << s_a[1:0];
                wr_data = {4{s_wd[7:0]}};
            end
            2'b01: begin
                lane_en = s_a[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{s_wd[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_data = s_wd;
            end
        endcase
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        load_val = '0;
        case (s_f3)
            3'b000: load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100: load_val = {24'd0, shifted[7:0]};
            3'b001: load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101: load_val = {16'd0, shifted[15:0]};
            3'b010: load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    // Storage array; contents survive reset. Writes land on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Request sequencing with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rd        <= '0;
            bus.err       <= 1'b0;
            a_q           <= '0;
            wd_q          <= '0;
            f3_q          <= '0;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    if (accept) begin
                        a_q           <= bus.a;
                        wd_q          <= bus.wd;
                        f3_q          <= bus.Funct3;
                        load_q        <= bus.MemRead & ~bus.MemWrite;
                        store_q       <= bus.MemWrite & ~bus.MemRead;
                        err_q         <= live_err;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                bus.rsp_valid <= 1'b1;
                bus.err       <= s_err;
                bus.rd        <= (s_load && !s_err) ? load_val : '0;
            end
        end
    end
endmodule

// File: tb/tb_datamemory_ctrl.sv
// Bench for datamemory_ctrl: three instances (1, 0 and 3 wait states) share one
// request stream; a byte-addressed model predicts every response cycle by cycle.
module tb_datamemory_ctrl;
    localparam int AW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic [2:0]    f3;

    datamemory_ctrl_if #(.DM_ADDRESS(AW)) bus1 ();
    datamemory_ctrl_if #(.DM_ADDRESS(AW)) bus0 ();
    datamemory_ctrl_if #(.DM_ADDRESS(AW)) bus3 ();

    assign bus1.req_valid = req_valid;
    assign bus1.MemRead   = mem_read;
    assign bus1.MemWrite  = mem_write;
    assign bus1.a         = a;
    assign bus1.wd        = wd;
    assign bus1.Funct3    = f3;
    assign bus0.req_valid = req_valid;
    assign bus0.MemRead   = mem_read;
    assign bus0.MemWrite  = mem_write;
    assign bus0.a         = a;
    assign bus0.wd        = wd;
    assign bus0.Funct3    = f3;
    assign bus3.req_valid = req_valid;
    assign bus3.MemRead   = mem_read;
    assign bus3.MemWrite  = mem_write;
    assign bus3.a         = a;
    assign bus3.wd        = wd;
    assign bus3.Funct3    = f3;

    datamemory_ctrl #(.DM_ADDRESS(AW), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    datamemory_ctrl #(.DM_ADDRESS(AW), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    datamemory_ctrl #(.DM_ADDRESS(AW), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // index 0: 1 wait state, 1: none, 2: 3 wait states
    logic [2:0]  o_rv;
    logic [2:0]  o_rdy;
    logic [2:0]  o_busy;
    logic [2:0]  o_err;
    logic [31:0] o_rd [3];
    assign o_rv   = {bus3.rsp_valid, bus0.rsp_valid, bus1.rsp_valid};
    assign o_rdy  = {bus3.req_ready, bus0.req_ready, bus1.req_ready};
    assign o_busy = {bus3.busy, bus0.busy, bus1.busy};
    assign o_err  = {bus3.err, bus0.err, bus1.err};
    assign o_rd[0] = bus1.rd;
    assign o_rd[1] = bus0.rd;
    assign o_rd[2] = bus3.rd;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int wk(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] mb [3][512];
    bit         act_m [3];
    int         ph_m  [3];
    bit         rdy_m [3];
    bit         err_m [3];
    bit [31:0]  rd_m  [3];
    bit         ld_m  [3];
    bit         st_m  [3];
    int         ad_m  [3];
    bit [31:0]  wd_m  [3];
    int         f3_m  [3];

    function automatic bit bad(input bit r, input bit w, input int f, input int ad);
        int sz;
        if (r && w) return 1'b1;
        if (r && (f == 3 || f >= 6)) return 1'b1;
        if (w && f > 2) return 1'b1;
        sz = 1 << (f % 4);
        return (ad % sz) != 0;
    endfunction

    task automatic commit(input int k);
        int sz;
        logic [31:0] v;
        sz = 1 << (f3_m[k] % 4);
        err_m[k] = bad(ld_m[k], st_m[k], f3_m[k], ad_m[k]);
        rd_m[k] = 32'd0;
        if (!err_m[k]) begin
            if (st_m[k]) begin
                for (int i = 0; i < sz; i++) mb[k][ad_m[k] + i] = 8'((wd_m[k] >> (8 * i)) & 32'hFF);
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mb[k][ad_m[k] + i]) << (8 * i));
                if (f3_m[k] < 4 && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
                rd_m[k] = v;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    act_m[k] = 1'b0;
                    ph_m[k]  = 0;
                    rdy_m[k] = 1'b0;
                    err_m[k] = 1'b0;
                    rd_m[k]  = 32'd0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (act_m[k]) begin
                        ph_m[k]++;
                        if (ph_m[k] == wk(k) + 1) act_m[k] = 1'b0;
                    end else if (rdy_m[k] && req_valid && (mem_read || mem_write)) begin
                        act_m[k] = 1'b1;
                        ph_m[k]  = 0;
                        ld_m[k]  = mem_read;
                        st_m[k]  = mem_write;
                        ad_m[k]  = int'(a);
                        wd_m[k]  = wd;
                        f3_m[k]  = int'(f3);
                    end
                    if (act_m[k] && ph_m[k] == wk(k)) commit(k);
                    rdy_m[k] = !act_m[k];
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bit exp_rv;
                exp_rv = rst_n && act_m[k] && (ph_m[k] == wk(k));
                chk($sformatf("W%0d rsp_valid", wk(k)), 32'(o_rv[k]), 32'(exp_rv));
                chk($sformatf("W%0d busy", wk(k)), 32'(o_busy[k]), 32'(act_m[k]));
                chk($sformatf("W%0d req_ready", wk(k)), 32'(o_rdy[k]), 32'(rdy_m[k]));
                if (exp_rv || !rst_n) begin
                    chk($sformatf("W%0d rd", wk(k)), o_rd[k], rd_m[k]);
                    chk($sformatf("W%0d err", wk(k)), 32'(o_err[k]), 32'(err_m[k]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (o_rdy != 3'b111 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle wait", 32'(o_rdy), 32'b111);
    endtask

    task automatic drive(input bit r, input bit w, input logic [AW-1:0] ad,
                         input logic [31:0] d, input logic [2:0] f);
        req_valid = 1'b1;
        mem_read  = r;
        mem_write = w;
        a         = ad;
        wd        = d;
        f3        = f;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Checks the 1-wait-state instance against hand-computed literals.
    task automatic xfer(input string name, input bit r, input bit w, input logic [AW-1:0] ad,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic [31:0] exp_rd, input bit exp_err);
        int n;
        wait_idle();
        drive(r, w, ad, d, f);
        n = 0;
        while (!o_rv[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " rsp"}, 32'(o_rv[0]), 32'd1);
        chk({name, " rd"}, o_rd[0], exp_rd);
        chk({name, " err"}, 32'(o_err[0]), 32'(exp_err));
    endtask

    initial begin
        int lat [3];
        int bc [3];
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        a         = '0;
        wd        = '0;
        f3        = '0;
        rst_n     = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("reset rsp_valid", 32'(o_rv), 32'd0);
        chk("reset req_ready", 32'(o_rdy), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset err", 32'(o_err), 32'd0);
        chk("reset rd", o_rd[0], 32'd0);
        #18 rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("SW 010", 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        xfer("LW 010", 1, 0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        xfer("SB 011", 0, 1, 9'h011, 32'h00000055, 3'b000, 32'h0, 0);
        xfer("LW 010 after SB", 1, 0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 0);
        xfer("LB 013", 1, 0, 9'h013, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
        xfer("LBU 013", 1, 0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 0);
        xfer("LH 012", 1, 0, 9'h012, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
        xfer("LHU 012", 1, 0, 9'h012, 32'h0, 3'b101, 32'h0000DEAD, 0);
        xfer("SH 012", 0, 1, 9'h012, 32'hFFFF1357, 3'b001, 32'h0, 0);
        xfer("LW after SH", 1, 0, 9'h010, 32'h0, 3'b010, 32'h135755EF, 0);
        xfer("SW misaligned", 0, 1, 9'h012, 32'h12345678, 3'b010, 32'h0, 1);
        xfer("LW unchanged", 1, 0, 9'h010, 32'h0, 3'b010, 32'h135755EF, 0);
        xfer("LH misaligned", 1, 0, 9'h001, 32'h0, 3'b001, 32'h0, 1);
        xfer("load f3 011", 1, 0, 9'h010, 32'h0, 3'b011, 32'h0, 1);
        xfer("store f3 100", 0, 1, 9'h010, 32'h0, 3'b100, 32'h0, 1);
        xfer("both ops", 1, 1, 9'h010, 32'h0, 3'b010, 32'h0, 1);
        xfer("LW after both", 1, 0, 9'h010, 32'h0, 3'b010, 32'h135755EF, 0);

        // request with neither op must be ignored
        wait_idle();
        req_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("ignored busy", 32'(o_busy), 32'd0);
        end
        req_valid = 1'b0;

        // top of the address space
        xfer("SW top", 0, 1, 9'h1FC, 32'hCAFEF00D, 3'b010, 32'h0, 0);
        xfer("LB top", 1, 0, 9'h1FF, 32'h0, 3'b000, 32'hFFFFFFCA, 0);
        xfer("LW top", 1, 0, 9'h1FC, 32'h0, 3'b010, 32'hCAFEF00D, 0);

        // latency and busy width for each wait-state count
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            bc[k]  = 0;
        end
        drive(1, 0, 9'h010, 32'h0, 3'b010);
        for (int m = 1; m <= 6; m++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (o_rv[k] && lat[k] == 0) lat[k] = m;
                if (o_busy[k]) bc[k]++;
            end
        end
        chk("W1 latency", 32'(lat[0]), 32'd2);
        chk("W0 latency", 32'(lat[1]), 32'd1);
        chk("W3 latency", 32'(lat[2]), 32'd4);
        chk("W1 busy cycles", 32'(bc[0]), 32'd2);
        chk("W0 busy cycles", 32'(bc[1]), 32'd1);
        chk("W3 busy cycles", 32'(bc[2]), 32'd4);

        // reset during WAIT of a store
        xfer("SW 020", 0, 1, 9'h020, 32'h11223344, 3'b010, 32'h0, 0);
        wait_idle();
        drive(0, 1, 9'h020, 32'hA5A5A5A5, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset rsp_valid", 32'(o_rv), 32'd0);
        chk("mid reset busy", 32'(o_busy), 32'd0);
        chk("mid reset req_ready", 32'(o_rdy), 32'd0);
        chk("mid reset err", 32'(o_err), 32'd0);
        chk("mid reset rd", o_rd[1], 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("LW 020 after reset", 1, 0, 9'h020, 32'h0, 3'b010, 32'h11223344, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/datamemory_ctrl.md
Name: datamemory_ctrl

Overview:
Parametrised, multi-cycle RV32 data memory controller. It replaces the single-cycle, word-only data memory, and sits in the MEM stage of the pipeline. It supports full RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with per-byte write enables, and has configurable wait states behind a valid/ready request and one-cycle response handshake. It also detects misaligned or illegal accesses and reports them as a response error instead of corrupting memory.

Parameters:
DM_ADDRESS, 9, byte-address width; depth = 2^(DM_ADDRESS-2) 32-bit words; legal range 3..20
WAIT_CYCLES, 1, extra cycles spent in WAIT before the response; legal range 0..15
DATA_W, 32, data width; fixed at 32 (funct3 semantics are RV32); elaboration error if not 32

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
MemRead  input  1  load request (from control unit)
MemWrite  input  1  store request (from control unit)
a  input  DM_ADDRESS  byte address (ALU result LSBs)
wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
Funct3  input  3  instruction bits 14:12
rsp_valid  output  1  one-cycle response strobe
rd  output  32  load result, extended per Funct3; 0 for stores and errors
err  output  1  qualified by rsp_valid: misaligned or illegal access
busy  output  1  high from acceptance through the RESP cycle; pipeline stall source

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=0, rsp_valid=0, rd=0, err=0, busy=0, wait counter=0. Memory contents are not reset. req_ready is 1 in IDLE only while rst_n is high.
- Acceptance: a request is accepted when req_valid && req_ready && (MemRead || MemWrite). At acceptance, a, Funct3, wd and the op are latched. A request with neither MemRead nor MemWrite is ignored (no state change).
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: on acceptance, go to WAIT with counter=WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: decrement the counter each cycle; when counter==0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+1 cycles. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles; req_ready is low in WAIT and RESP.
- Error detection happens at acceptance and is latched:
  - Illegal funct3 for loads: 011, 110, 111.
  - Illegal funct3 for stores: anything other than 000/001/010.
  - Misaligned: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0.
  - MemRead and MemWrite both high.
  - On error: no memory write; the response still follows normal latency with err=1, rd=0.
- Store write timing: the byte-lane write is committed on the edge that enters RESP, for non-error stores only.
  - Word index = a[DM_ADDRESS-1:2].
  - SB: lane a[1:0] <= wd[7:0].
  - SH: lanes {a[1],0} and {a[1],1} <= wd[15:0].
  - SW: all four lanes.
  - Unselected lanes are unchanged.
- Load: reads the word at the word index, selects the byte by a[1:0] or the half by a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
  - rd is registered and valid with rsp_valid.
  - A load issued after a store observes the stored data (the write is committed before the next acceptance).
- rd and err hold their last values outside rsp_valid; they are meaningful only with rsp_valid.
- Reset mid-operation: an in-flight request is abandoned. If rst_n falls before the RESP-entry edge, the memory is unmodified and no response is produced.
- Top word/byte (a = all ones with a legal width) accesses the last word; there is no wrap or aliasing beyond DM_ADDRESS bits.

Test Plan:
1. WAIT_CYCLES=1: SW a=0x010 wd=0xDEADBEEF, then LW a=0x010 -> rsp_valid 2 cycles after each acceptance, rd=0xDEADBEEF, err=0; req_ready low for 2 cycles after each acceptance.
2. Word 0x010 holding 0xDEADBEEF: SB a=0x011 wd=0x55, then LW -> 0xDEAD55EF. Then LB a=0x013 -> 0xFFFFFFDE; LBU a=0x013 -> 0x000000DE; LH a=0x012 -> 0xFFFFDEAD; LHU a=0x012 -> 0x0000DEAD.
3. Misaligned: SW a=0x012 wd=0x12345678 -> err=1, rd=0, and a following LW a=0x010 returns the unchanged word. LH a=0x001 -> err=1. Funct3=011 load -> err=1.
4. MemRead=MemWrite=1 -> err=1, no write. req_valid=1 with both ops low -> no acceptance, busy stays 0.
5. WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: response latency is 1 and 4 cycles respectively, and busy covers exactly the cycles from acceptance through RESP.
6. Assert rst_n low during WAIT of SW a=0x020 wd=0xA5A5A5A5 -> outputs return to reset values immediately and no rsp_valid pulse. After release, LW a=0x020 returns the prior contents.
